// File: rtl/timer_slave_if.sv
// Bus bundle between the CPU data port and the timer peripheral.
// The CPU side (master) drives select, direction, offset and write data;
// the timer (slave) returns registered read data and the interrupt level.
interface timer_slave_if;

    logic        cs_timer_n;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output cs_timer_n,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  cs_timer_n,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output irq
    );

endinterface

// File: rtl/timer_slave.sv
// Memory-mapped timer peripheral living in the 0x8000_1xxx window.
// A prescaled 32-bit up-counter with compare match, overflow flag and a
// level interrupt. Read data is registered so that the peripheral shows the
// same one-cycle read latency as the synchronous data memory, and it returns
// zero whenever it is not being read so it can be OR-ed onto the bus.
module timer_slave #(
    parameter int          PSC_W     = 16,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    timer_slave_if.slave bus
);

    // Word index taken from addr[4:2]; indices 5..7 are unmapped.
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_COUNT    = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_STATUS   = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_UNMAP5   = 3'd5,
        REG_UNMAP6   = 3'd6,
        REG_UNMAP7   = 3'd7
    } regIdx_t;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Architectural state
    logic [2:0]       r_ctrl;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_match;
    logic             r_ovf;
    logic [PSC_W-1:0] r_prescale;
    logic [PSC_W-1:0] r_pscCnt;
    logic [31:0]      r_rdata;
    logic             r_irq;

    // Decode results
    regIdx_t          w_regIdx;
    logic             w_sel;
    logic             w_wr;
    logic             w_rd;
    logic             w_wrCtrl;
    logic             w_wrCount;
    logic             w_wrCompare;
    logic             w_wrStatus;
    logic             w_wrPrescale;

    // Counter datapath
    logic             w_tick;
    logic             w_advance;
    logic             w_cmpHit;
    logic             w_setMatch;
    logic             w_reload;
    logic             w_setOvf;
    logic [31:0]      w_readData;

    // Only addr[4:2] selects a register; the rest of the offset is ignored.
    logic             w_unusedAddrBits;
    assign w_unusedAddrBits = ^{bus.addr[11:5], bus.addr[1:0]};

    // Decode the chip select, direction and register index into per-register strobes.
    always_comb begin
        w_sel        = 1'b0;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_wrCtrl     = 1'b0;
        w_wrCount    = 1'b0;
        w_wrCompare  = 1'b0;
        w_wrStatus   = 1'b0;
        w_wrPrescale = 1'b0;
        w_regIdx     = regIdx_t'(bus.addr[4:2]);

        w_sel = ~bus.cs_timer_n;
        w_wr  = w_sel & bus.we;
        w_rd  = w_sel & ~bus.we;

        if (w_wr) begin
            case (w_regIdx)
                REG_CTRL:     w_wrCtrl     = 1'b1;
                REG_COUNT:    w_wrCount    = 1'b1;
                REG_COMPARE:  w_wrCompare  = 1'b1;
                REG_STATUS:   w_wrStatus   = 1'b1;
                REG_PRESCALE: w_wrPrescale = 1'b1;
                default:      ;
            endcase
        end
    end

    // Work out what a prescaler tick does this cycle; a CPU write to COUNT overrides the tick.
    always_comb begin
        w_tick     = 1'b0;
        w_advance  = 1'b0;
        w_cmpHit   = 1'b0;
        w_setMatch = 1'b0;
        w_reload   = 1'b0;
        w_setOvf   = 1'b0;

        w_tick     = r_ctrl[CTRL_EN] && (r_pscCnt == r_prescale);
        w_advance  = w_tick && !w_wrCount;
        w_cmpHit   = (r_count == r_compare);
        w_setMatch = w_advance && w_cmpHit;
        w_reload   = w_setMatch && r_ctrl[CTRL_AUTO];
        w_setOvf   = w_advance && !w_reload && (r_count == 32'hFFFF_FFFF);
    end

    // Control register: only the three defined bits are stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 3'b000;
        end else if (w_wrCtrl) begin
            r_ctrl <= bus.wdata[2:0];
        end
    end

    // Compare and prescale registers; a new COMPARE is only seen by later ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_compare  <= CMP_RESET;
            r_prescale <= '0;
        end else begin
            if (w_wrCompare) begin
                r_compare <= bus.wdata;
            end
            if (w_wrPrescale) begin
                r_prescale <= bus.wdata[PSC_W-1:0];
            end
        end
    end

    // Prescale counter: runs 0..PRESCALE while enabled, restarts on COUNT or PRESCALE writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pscCnt <= '0;
        end else if (w_wrCount || w_wrPrescale) begin
            r_pscCnt <= '0;
        end else if (r_ctrl[CTRL_EN]) begin
            if (w_tick) begin
                r_pscCnt <= '0;
            end else begin
                r_pscCnt <= r_pscCnt + 1'b1;
            end
        end
    end

    // Main counter: CPU write wins, otherwise advance (or reload on match) on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_wrCount) begin
            r_count <= bus.wdata;
        end else if (w_advance) begin
            if (w_reload) begin
                r_count <= 32'd0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Sticky status flags: a hardware set in the same cycle beats a write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_match <= w_setMatch | (r_match & ~(w_wrStatus & bus.wdata[0]));
            r_ovf   <= w_setOvf   | (r_ovf   & ~(w_wrStatus & bus.wdata[1]));
        end
    end

    // Read multiplexer; unmapped offsets and unused bits read as zero.
    always_comb begin
        w_readData = 32'd0;
        case (w_regIdx)
            REG_CTRL:     w_readData = {29'd0, r_ctrl};
            REG_COUNT:    w_readData = r_count;
            REG_COMPARE:  w_readData = r_compare;
            REG_STATUS:   w_readData = {30'd0, r_ovf, r_match};
            REG_PRESCALE: w_readData = 32'(r_prescale);
            default:      w_readData = 32'd0;
        endcase
    end

    // Registered read data, forced to zero whenever this slave is not being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= w_readData;
        end else begin
            r_rdata <= 32'd0;
        end
    end

    // Interrupt follows the stored MATCH flag gated by IRQ_EN, one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_match & r_ctrl[CTRL_IRQ_EN];
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.irq   = r_irq;

endmodule

// File: tb/tb_timer_slave.sv
// Directed bench for the timer peripheral. Every bus operation occupies
// exactly one rising edge: inputs change on the falling edge, and outputs are
// sampled on the falling edge that follows the operation's rising edge.
module tb_timer_slave;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    timer_slave_if busIf ();

    timer_slave #(
        .PSC_W     (16),
        .CMP_RESET (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf.slave)
    );

    localparam logic [11:0] OFS_CTRL     = 12'h000;
    localparam logic [11:0] OFS_COUNT    = 12'h004;
    localparam logic [11:0] OFS_COMPARE  = 12'h008;
    localparam logic [11:0] OFS_STATUS   = 12'h00C;
    localparam logic [11:0] OFS_PRESCALE = 12'h010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive at the current falling edge, let one rising edge pass.
    task automatic applyStimulus(input logic isWrite, input logic [11:0] offset,
                                 input logic [31:0] data);
        busIf.cs_timer_n = 1'b0;
        busIf.we         = isWrite;
        busIf.addr       = offset;
        busIf.wdata      = data;
        @(negedge clk);
        busIf.cs_timer_n = 1'b1;
        busIf.we         = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic readAndCheck(input string tag, input logic [11:0] offset,
                                input logic [31:0] expected);
        applyStimulus(1'b0, offset, 32'd0);
        checkOutput(tag, busIf.rdata, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        busIf.cs_timer_n = 1'b1;
        busIf.we         = 1'b0;
        busIf.addr       = 12'h000;
        busIf.wdata      = 32'd0;

        // Power-on reset
        idle(2);
        checkOutput("por_rdata", busIf.rdata, 32'd0);
        checkOutput("por_irq", {31'd0, busIf.irq}, 32'd0);
        reset = 1'b0;

        // Register read/write
        applyStimulus(1'b1, OFS_COMPARE, 32'h0000_1234);
        readAndCheck("rd_compare", OFS_COMPARE, 32'h0000_1234);
        applyStimulus(1'b1, OFS_PRESCALE, 32'hFFFF_0003);
        readAndCheck("rd_prescale", OFS_PRESCALE, 32'h0000_0003);
        idle(1);
        checkOutput("rdata_idle_zero", busIf.rdata, 32'd0);
        readAndCheck("rd_unmapped_18", 12'h018, 32'd0);
        readAndCheck("rd_addr_low_bits", 12'h00B, 32'h0000_1234);
        busIf.cs_timer_n = 1'b1;
        busIf.we         = 1'b1;
        busIf.addr       = OFS_COMPARE;
        busIf.wdata      = 32'hDEAD_BEEF;
        @(negedge clk);
        busIf.we         = 1'b0;
        readAndCheck("no_write_unselected", OFS_COMPARE, 32'h0000_1234);
        applyStimulus(1'b1, OFS_CTRL, 32'hFFFF_FFF8);
        readAndCheck("ctrl_unused_bits", OFS_CTRL, 32'd0);
        readAndCheck("status_reset", OFS_STATUS, 32'd0);

        // Prescaler: PRESCALE=3, COUNT steps every fourth cycle
        applyStimulus(1'b1, OFS_CTRL, 32'h1);
        idle(6);
        readAndCheck("psc_count_a", OFS_COUNT, 32'd1);
        readAndCheck("psc_count_b", OFS_COUNT, 32'd1);
        readAndCheck("psc_count_c", OFS_COUNT, 32'd2);
        applyStimulus(1'b1, OFS_CTRL, 32'h0);
        idle(8);
        readAndCheck("en0_freeze", OFS_COUNT, 32'd2);

        // Match, auto-reload and interrupt with PRESCALE=0
        applyStimulus(1'b1, OFS_PRESCALE, 32'd0);
        applyStimulus(1'b1, OFS_COUNT, 32'd0);
        applyStimulus(1'b1, OFS_COMPARE, 32'd5);
        applyStimulus(1'b1, OFS_CTRL, 32'h7);
        idle(6);
        checkOutput("irq_before_match", {31'd0, busIf.irq}, 32'd0);
        idle(1);
        checkOutput("irq_after_match", {31'd0, busIf.irq}, 32'd1);
        readAndCheck("status_match", OFS_STATUS, 32'h1);
        applyStimulus(1'b1, OFS_STATUS, 32'h1);
        checkOutput("irq_hold_w1c_edge", {31'd0, busIf.irq}, 32'd1);
        idle(1);
        checkOutput("irq_drop_after_w1c", {31'd0, busIf.irq}, 32'd0);
        idle(1);
        applyStimulus(1'b1, OFS_STATUS, 32'h1);
        readAndCheck("set_beats_w1c", OFS_STATUS, 32'h1);
        checkOutput("irq_rearm", {31'd0, busIf.irq}, 32'd1);

        // Reset in the middle of counting, with a read in flight
        reset            = 1'b1;
        busIf.cs_timer_n = 1'b0;
        busIf.we         = 1'b0;
        busIf.addr       = OFS_COUNT;
        idle(2);
        checkOutput("mid_reset_rdata", busIf.rdata, 32'd0);
        checkOutput("mid_reset_irq", {31'd0, busIf.irq}, 32'd0);
        busIf.cs_timer_n = 1'b1;
        reset            = 1'b0;
        readAndCheck("rst_ctrl", OFS_CTRL, 32'd0);
        readAndCheck("rst_count", OFS_COUNT, 32'd0);
        readAndCheck("rst_compare", OFS_COMPARE, 32'hFFFF_FFFF);
        readAndCheck("rst_status", OFS_STATUS, 32'd0);
        readAndCheck("rst_prescale", OFS_PRESCALE, 32'd0);

        // Overflow followed by a match at COUNT=0, no auto-reload
        applyStimulus(1'b1, OFS_COUNT, 32'hFFFF_FFFE);
        applyStimulus(1'b1, OFS_COMPARE, 32'd0);
        applyStimulus(1'b1, OFS_CTRL, 32'h1);
        idle(2);
        readAndCheck("ovf_count_wrap", OFS_COUNT, 32'd0);
        readAndCheck("ovf_then_match", OFS_STATUS, 32'h3);
        checkOutput("irq_masked", {31'd0, busIf.irq}, 32'd0);
        applyStimulus(1'b1, OFS_CTRL, 32'h0);
        readAndCheck("ovf_count_after", OFS_COUNT, 32'd3);

        // CPU write to COUNT on a tick edge wins and restarts the prescaler
        applyStimulus(1'b1, OFS_STATUS, 32'h3);
        readAndCheck("status_w1c_both", OFS_STATUS, 32'd0);
        applyStimulus(1'b1, OFS_PRESCALE, 32'd1);
        applyStimulus(1'b1, OFS_COMPARE, 32'hFFFF_FFFF);
        applyStimulus(1'b1, OFS_COUNT, 32'd0);
        applyStimulus(1'b1, OFS_CTRL, 32'h1);
        idle(3);
        applyStimulus(1'b1, OFS_COUNT, 32'h10);
        readAndCheck("wr_count_on_tick", OFS_COUNT, 32'h10);
        readAndCheck("psc_restart_hold", OFS_COUNT, 32'h10);
        readAndCheck("psc_restart_step", OFS_COUNT, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
